// File: rtl/dp_ram_port_arbiter.sv
// Round-robin arbiter sharing one dp_ram port between NUM_REQ requesters, with a tag pipe routing read data back.
// Optional feature: define RAM_ARB_LOCK_EN to let a requester hold the grant across beats via REQ_LOCK.
module dp_ram_port_arbiter #(
   parameter int  NUM_REQ    = 4,
   parameter int  DATA_WIDTH = 32,
   parameter int  DEPTH      = 12,
   parameter int  RD_LATENCY = 1,
   localparam int ADDR_WIDTH = $clog2(DEPTH),
   localparam int WE_WIDTH   = DATA_WIDTH / 8,
   localparam int IDX_WIDTH  = $clog2(NUM_REQ)
) (
   input  logic                             CLK,
   input  logic                             RST,
   input  logic [NUM_REQ-1:0]               REQ_VALID,
   output logic [NUM_REQ-1:0]               REQ_READY,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    REQ_ADDR,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    REQ_WDATA,
   input  logic [NUM_REQ*WE_WIDTH-1:0]      REQ_WE,
   input  logic [NUM_REQ-1:0]               REQ_LOCK,
   output logic [NUM_REQ-1:0]               RSP_VALID,
   output logic [DATA_WIDTH-1:0]            RSP_RDATA,
   output logic [ADDR_WIDTH-1:0]            RAM_ADDR,
   output logic [DATA_WIDTH-1:0]            RAM_WDATA,
   output logic [WE_WIDTH-1:0]              RAM_WE,
   input  logic [DATA_WIDTH-1:0]            RAM_RDATA,
   output logic [IDX_WIDTH-1:0]             GRANT_IDX,
   output logic [1:0]                       dbg_state
);

   // Command handshake: a beat transfers in a cycle where REQ_VALID[i] & REQ_READY[i]; the requester
   // holds its fields stable while VALID=1 and READY=0. Responses are one-cycle strobes with no backpressure.

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARB    = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t                 state;
   logic [IDX_WIDTH-1:0]   rr_ptr;
   logic                   hi_found, lo_found, win_found, accept, any_valid;
   logic [IDX_WIDTH-1:0]   hi_idx, lo_idx, win_idx, next_ptr;
   logic [ADDR_WIDTH-1:0]  win_addr;
   logic [DATA_WIDTH-1:0]  win_wdata;
   logic [WE_WIDTH-1:0]    win_we;
   logic                   tag_v   [0:RD_LATENCY];
   logic [IDX_WIDTH-1:0]   tag_idx [0:RD_LATENCY];

`ifdef RAM_ARB_LOCK_EN
   logic                   win_lock;
   logic [IDX_WIDTH-1:0]   lock_idx;
`else
   logic                   unused_lock;
   assign unused_lock = ^REQ_LOCK;
`endif

   assign any_valid = |REQ_VALID;
   assign accept    = win_found;
   assign next_ptr  = (win_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + IDX_WIDTH'(1);
   assign dbg_state = state;

   // Lowest valid index at/after the pointer wins; otherwise the lowest valid index below it (wrap).
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (REQ_VALID[i]) begin
            if (IDX_WIDTH'(i) >= rr_ptr) begin
               hi_found = 1'b1;
               hi_idx   = IDX_WIDTH'(i);
            end else begin
               lo_found = 1'b1;
               lo_idx   = IDX_WIDTH'(i);
            end
         end
      end
      win_found = hi_found | lo_found;
      win_idx   = hi_found ? hi_idx : lo_idx;
`ifdef RAM_ARB_LOCK_EN
      if (state == ST_LOCKED) begin
         win_found = 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_WIDTH'(i) == lock_idx) win_found = REQ_VALID[i];
         end
         win_idx = lock_idx;
      end
`endif
      for (int i = 0; i < NUM_REQ; i++) begin
         REQ_READY[i] = win_found && (win_idx == IDX_WIDTH'(i));
      end
   end

   always_comb begin
      win_addr  = '0;
      win_wdata = '0;
      win_we    = '0;
`ifdef RAM_ARB_LOCK_EN
      win_lock  = 1'b0;
`endif
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == IDX_WIDTH'(i)) begin
            win_addr  = REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
            win_wdata = REQ_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
            win_we    = REQ_WE[i*WE_WIDTH +: WE_WIDTH];
`ifdef RAM_ARB_LOCK_EN
            win_lock  = REQ_LOCK[i];
`endif
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= ST_IDLE;
         rr_ptr    <= '0;
         RAM_ADDR  <= '0;
         RAM_WDATA <= '0;
         RAM_WE    <= '0;
         GRANT_IDX <= '0;
`ifdef RAM_ARB_LOCK_EN
         lock_idx  <= '0;
`endif
         for (int s = 0; s <= RD_LATENCY; s++) begin
            tag_v[s]   <= 1'b0;
            tag_idx[s] <= '0;
         end
      end else begin
         RAM_WE <= '0;
         if (accept) begin
            RAM_ADDR  <= win_addr;
            RAM_WDATA <= win_wdata;
            RAM_WE    <= win_we;
            GRANT_IDX <= win_idx;
            rr_ptr    <= next_ptr;
         end
         // Stage k holds reads accepted k+1 cycles ago; the last stage lines up with RAM_RDATA.
         tag_v[0]   <= accept && (win_we == '0);
         tag_idx[0] <= win_idx;
         for (int s = 1; s <= RD_LATENCY; s++) begin
            tag_v[s]   <= tag_v[s-1];
            tag_idx[s] <= tag_idx[s-1];
         end
`ifdef RAM_ARB_LOCK_EN
         if (accept && win_lock) begin
            state    <= ST_LOCKED;
            lock_idx <= win_idx;
         end else if (state == ST_LOCKED) begin
            state <= accept ? ST_ARB : ST_LOCKED;
         end else begin
            state <= any_valid ? ST_ARB : ST_IDLE;
         end
`else
         state <= any_valid ? ST_ARB : ST_IDLE;
`endif
      end
   end

   always_comb begin
      RSP_VALID = '0;
      RSP_RDATA = '0;
      if (tag_v[RD_LATENCY]) begin
         RSP_RDATA = RAM_RDATA;
         for (int i = 0; i < NUM_REQ; i++) begin
            RSP_VALID[i] = (tag_idx[RD_LATENCY] == IDX_WIDTH'(i));
         end
      end
   end

endmodule

// File: tb/tb_dp_ram_port_arbiter.sv
// Scoreboard bench for dp_ram_port_arbiter: RD_LATENCY=1 instance with a write-first RAM model,
// plus an RD_LATENCY=3 instance for back-to-back read latency.
module tb_dp_ram_port_arbiter;
   localparam int NR = 4;
   localparam int DW = 32;
   localparam int DEPTH = 12;
   localparam int AW = 4;
   localparam int WEW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              RST;
   logic [NR-1:0]     REQ_VALID, REQ_READY, REQ_LOCK, RSP_VALID;
   logic [NR*AW-1:0]  REQ_ADDR;
   logic [NR*DW-1:0]  REQ_WDATA;
   logic [NR*WEW-1:0] REQ_WE;
   logic [DW-1:0]     RSP_RDATA, RAM_WDATA, RAM_RDATA;
   logic [AW-1:0]     RAM_ADDR;
   logic [WEW-1:0]    RAM_WE;
   logic [1:0]        GRANT_IDX, dbg_state;

   logic [NR-1:0]     REQ_VALID3, REQ_READY3, RSP_VALID3;
   logic [NR*AW-1:0]  REQ_ADDR3;
   logic [NR*DW-1:0]  REQ_WDATA3;
   logic [NR*WEW-1:0] REQ_WE3;
   logic [DW-1:0]     RSP_RDATA3, RAM_WDATA3, RAM_RDATA3;
   logic [AW-1:0]     RAM_ADDR3;
   logic [WEW-1:0]    RAM_WE3;
   logic [1:0]        GRANT_IDX3, dbg_state3;

   dp_ram_port_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LATENCY(1)) dut (
      .CLK(clk), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
      .REQ_WDATA(REQ_WDATA), .REQ_WE(REQ_WE), .REQ_LOCK(REQ_LOCK), .RSP_VALID(RSP_VALID),
      .RSP_RDATA(RSP_RDATA), .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA), .RAM_WE(RAM_WE),
      .RAM_RDATA(RAM_RDATA), .GRANT_IDX(GRANT_IDX), .dbg_state(dbg_state));

   dp_ram_port_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LATENCY(3)) dut3 (
      .CLK(clk), .RST(RST), .REQ_VALID(REQ_VALID3), .REQ_READY(REQ_READY3), .REQ_ADDR(REQ_ADDR3),
      .REQ_WDATA(REQ_WDATA3), .REQ_WE(REQ_WE3), .REQ_LOCK(4'b0000), .RSP_VALID(RSP_VALID3),
      .RSP_RDATA(RSP_RDATA3), .RAM_ADDR(RAM_ADDR3), .RAM_WDATA(RAM_WDATA3), .RAM_WE(RAM_WE3),
      .RAM_RDATA(RAM_RDATA3), .GRANT_IDX(GRANT_IDX3), .dbg_state(dbg_state3));

   // ---------------- clock/cycle count and RAM models ----------------
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DW-1:0] mem [0:DEPTH-1];
   logic [DW-1:0] rd1 = '0;
   assign RAM_RDATA = rd1;
   always @(posedge clk) begin
      if (int'(RAM_ADDR) < DEPTH) begin
         for (int b = 0; b < WEW; b++) begin
            if (RAM_WE[b]) mem[RAM_ADDR][b*8 +: 8] = RAM_WDATA[b*8 +: 8];
         end
         rd1 <= mem[RAM_ADDR];
      end
   end

   logic [DW-1:0] p3 [0:2];
   assign RAM_RDATA3 = p3[2];
   always @(posedge clk) begin
      p3[0] <= 32'hC0DE_0000 | 32'(RAM_ADDR3);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail = 0;
   logic [55:0] exp_q[$];   // {due_cycle[55:40], idx[39:32], data[31:0]}
   logic [55:0] exp3_q[$];
   logic [1:0]  gnt_q[$];
   logic [55:0] e1, e3;
   logic [1:0]  g1;
   logic [3:0]  oh;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (RSP_VALID != '0) begin
         if (exp_q.size() == 0) check("rsp_unexpected", 64'(RSP_VALID), 64'd0);
         else begin
            e1 = exp_q.pop_front();
            oh = 4'b0001 << e1[39:32];
            check("rsp_valid", 64'(RSP_VALID), 64'(oh));
            check("rsp_rdata", 64'(RSP_RDATA), 64'(e1[31:0]));
            check("rsp_cycle", 64'(cyc), 64'(e1[55:40]));
         end
      end else if (exp_q.size() != 0 && int'(exp_q[0][55:40]) < cyc) begin
         e1 = exp_q.pop_front();
         oh = 4'b0001 << e1[39:32];
         check("rsp_missing", 64'(RSP_VALID), 64'(oh));
      end
   end

   always @(negedge clk) begin
      if (RSP_VALID3 != '0) begin
         if (exp3_q.size() == 0) check("rsp3_unexpected", 64'(RSP_VALID3), 64'd0);
         else begin
            e3 = exp3_q.pop_front();
            oh = 4'b0001 << e3[39:32];
            check("rsp3_valid", 64'(RSP_VALID3), 64'(oh));
            check("rsp3_rdata", 64'(RSP_RDATA3), 64'(e3[31:0]));
            check("rsp3_cycle", 64'(cyc), 64'(e3[55:40]));
         end
      end else if (exp3_q.size() != 0 && int'(exp3_q[0][55:40]) < cyc) begin
         e3 = exp3_q.pop_front();
         oh = 4'b0001 << e3[39:32];
         check("rsp3_missing", 64'(RSP_VALID3), 64'(oh));
      end
   end

   always @(negedge clk) begin
      if (!RST && (REQ_READY & ~REQ_VALID) != '0)
         check("ready_without_valid", 64'(REQ_READY & ~REQ_VALID), 64'd0);
      if (!RST && (REQ_VALID & REQ_READY) != '0) begin
         if (gnt_q.size() == 0) check("gnt_unexpected", 64'(REQ_READY), 64'd0);
         else begin
            g1 = gnt_q.pop_front();
            oh = 4'b0001 << g1;
            check("gnt_order", 64'(REQ_READY), 64'(oh));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_fields(input int i, input int addr, input logic [31:0] wd,
                             input logic [3:0] we, input logic lk);
      REQ_ADDR[i*AW +: AW]    = addr[3:0];
      REQ_WDATA[i*DW +: DW]   = wd;
      REQ_WE[i*WEW +: WEW]    = we;
      REQ_LOCK[i]             = lk;
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after the accept.
   task automatic cmd(input int i, input int addr, input logic [31:0] wd,
                      input logic [3:0] we, input logic [31:0] exp_rd);
      logic got;
      got = 1'b0;
      gnt_q.push_back(2'(i));
      set_fields(i, addr, wd, we, 1'b0);
      REQ_VALID[i] = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (REQ_READY[i]) begin
            got = 1'b1;
            if (we == 4'h0) exp_q.push_back({16'(cyc + 2), 8'(i), exp_rd});
         end
         @(posedge clk); #1;
         if (got) break;
      end
      REQ_VALID[i] = 1'b0;
      if (!got) check("accept_timeout", 64'(REQ_READY), 64'(4'b0001 << i));
   endtask

   task automatic multi(input logic [3:0] v, input int n);
      REQ_VALID = v;
      repeat (n) begin @(posedge clk); #1; end
      REQ_VALID = '0;
   endtask

   // ---------------- stimulus ----------------
   logic [3:0] seen;
   initial begin
      RST = 1'b1;
      REQ_VALID = '0; REQ_ADDR = '0; REQ_WDATA = '0; REQ_WE = '0; REQ_LOCK = '0;
      REQ_VALID3 = '0; REQ_ADDR3 = '0; REQ_WDATA3 = '0; REQ_WE3 = '0;
      for (int a = 0; a < DEPTH; a++) mem[a] = '0;
      repeat (3) @(posedge clk);
      #1 RST = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_req_ready", 64'(REQ_READY), 64'd0);
      check("rst_rsp_valid", 64'(RSP_VALID), 64'd0);
      check("rst_rsp_rdata", 64'(RSP_RDATA), 64'd0);
      check("rst_ram_addr", 64'(RAM_ADDR), 64'd0);
      check("rst_ram_wdata", 64'(RAM_WDATA), 64'd0);
      check("rst_ram_we", 64'(RAM_WE), 64'd0);
      check("rst_grant_idx", 64'(GRANT_IDX), 64'd0);
      check("rst_state", 64'(dbg_state), 64'd0);
      @(posedge clk); #1;

      // All four valid from reset: round-robin 0,1,2,3,0,1,2,3 (writes to addr 8..11)
      for (int i = 0; i < NR; i++) set_fields(i, 8 + i, 32'hA0A0_0000 + 32'(i), 4'hF, 1'b0);
      for (int r = 0; r < 2; r++) for (int i = 0; i < NR; i++) gnt_q.push_back(2'(i));
      REQ_VALID = 4'hF;
      @(posedge clk); #1;
      check("state_arb", 64'(dbg_state), 64'd1);
      repeat (7) begin @(posedge clk); #1; end
      REQ_VALID = '0;

      // Read back the round-robin writes from different requesters
      cmd(3, 8,  32'h0, 4'h0, 32'hA0A0_0000);
      cmd(1, 9,  32'h0, 4'h0, 32'hA0A0_0001);
      cmd(0, 10, 32'h0, 4'h0, 32'hA0A0_0002);
      cmd(2, 11, 32'h0, 4'h0, 32'hA0A0_0003);

      // Write then read addr 5 from req0; RAM port carries registered copies
      cmd(0, 5, 32'hDEAD_BEEF, 4'hF, 32'h0);
      check("wr_ram_we", 64'(RAM_WE), 64'hF);
      check("wr_ram_addr", 64'(RAM_ADDR), 64'd5);
      check("wr_ram_wdata", 64'(RAM_WDATA), 64'hDEAD_BEEF);
      check("wr_grant_idx", 64'(GRANT_IDX), 64'd0);
      cmd(0, 5, 32'h0, 4'h0, 32'hDEAD_BEEF);
      check("rd_ram_we", 64'(RAM_WE), 64'd0);
      check("rd_ram_addr", 64'(RAM_ADDR), 64'd5);
      check("rd_ram_wdata", 64'(RAM_WDATA), 64'd0);
      @(posedge clk); #1;
      check("idle_ram_we", 64'(RAM_WE), 64'd0);
      check("idle_ram_addr_hold", 64'(RAM_ADDR), 64'd5);

      // Byte-strobe merge on addr 3
      cmd(1, 3, 32'h1122_3344, 4'hF, 32'h0);
      cmd(2, 3, 32'h0000_00AB, 4'b0001, 32'h0);
      cmd(2, 3, 32'h0, 4'h0, 32'h1122_33AB);
      check("merge_grant_idx", 64'(GRANT_IDX), 64'd2);

      // Lock: pointer set to 1 first, then req0/req2 valid while req1 sends LOCK=1,1,0
      cmd(0, 0, 32'h0000_0100, 4'hF, 32'h0);
      set_fields(0, 0, 32'h0000_0200, 4'hF, 1'b0);
      set_fields(1, 1, 32'h0000_0201, 4'hF, 1'b1);
      set_fields(2, 2, 32'h0000_0202, 4'hF, 1'b0);
`ifdef RAM_ARB_LOCK_EN
      gnt_q.push_back(2'd1); gnt_q.push_back(2'd1); gnt_q.push_back(2'd1);
      gnt_q.push_back(2'd2); gnt_q.push_back(2'd0);
`else
      gnt_q.push_back(2'd1); gnt_q.push_back(2'd2); gnt_q.push_back(2'd0);
      gnt_q.push_back(2'd2); gnt_q.push_back(2'd0);
`endif
      REQ_VALID = 4'b0111;
      @(posedge clk); #1;
`ifdef RAM_ARB_LOCK_EN
      check("state_locked", 64'(dbg_state), 64'd2);
`else
      check("state_unlocked", 64'(dbg_state), 64'd1);
`endif
      @(posedge clk); #1;
      REQ_LOCK[1] = 1'b0;
      @(posedge clk); #1;
      REQ_VALID = 4'b0101;
      repeat (2) begin @(posedge clk); #1; end
      REQ_VALID = '0;

      // Reset right after a read accept from req1 drops the response
      set_fields(1, 5, 32'h0, 4'h0, 1'b0);
      gnt_q.push_back(2'd1);
      REQ_VALID = 4'b0010;
      @(posedge clk); #1;
      REQ_VALID = '0;
      RST = 1'b1;
      @(negedge clk);
      check("rstmid_ram_we", 64'(RAM_WE), 64'd0);
      @(posedge clk); #1;
      RST = 1'b0;
      seen = '0;
      @(negedge clk);
      check("rstmid_grant_idx", 64'(GRANT_IDX), 64'd0);
      check("rstmid_state", 64'(dbg_state), 64'd0);
      seen = seen | RSP_VALID;
      repeat (3) begin @(negedge clk); seen = seen | RSP_VALID; end
      check("rstmid_no_rsp", 64'(seen), 64'd0);
      @(posedge clk); #1;
      set_fields(0, 6, 32'h0000_0300, 4'hF, 1'b0);
      set_fields(3, 7, 32'h0000_0303, 4'hF, 1'b0);
      gnt_q.push_back(2'd0); gnt_q.push_back(2'd3);
      multi(4'b1001, 2);

      // RD_LATENCY=3: reads from req0, req3, req1 in consecutive cycles
      REQ_ADDR3 = {4'd7, 4'd0, 4'd10, 4'd2};
      REQ_VALID3 = 4'b0001;
      exp3_q.push_back({16'(cyc + 4), 8'd0, 32'hC0DE_0002});
      @(posedge clk); #1;
      REQ_VALID3 = 4'b1000;
      exp3_q.push_back({16'(cyc + 4), 8'd3, 32'hC0DE_0007});
      @(posedge clk); #1;
      REQ_VALID3 = 4'b0010;
      exp3_q.push_back({16'(cyc + 4), 8'd1, 32'hC0DE_000A});
      @(posedge clk); #1;
      REQ_VALID3 = '0;

      // Drain and report
      repeat (10) @(posedge clk);
      #1;
      check("exp_q_drained", 64'(exp_q.size()), 64'd0);
      check("exp3_q_drained", 64'(exp3_q.size()), 64'd0);
      check("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete, %0d failures so far", n_fail);
      $fatal(1);
   end

endmodule
